// File: rtl/clz_pkg.sv
// Shared encodings and helpers for the CLZ/CLS normaliser.
// Optional barrel shifter is enabled by defining CLZ_NORM_SHIFT_EN.
package clz_pkg;

    localparam logic CLZ_MODE_LZ = 1'b0;
    localparam logic CLZ_MODE_LS = 1'b1;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/clz_group.sv
// Combinational priority encoder for one GROUP_W slice:
// reports whether the slice is empty and its local leading-zero count.
module clz_group
    import clz_pkg::*;
#(
    parameter int GROUP_W = 8,
    localparam int LCNT_W = cnt_w(GROUP_W)
) (
    input  logic [GROUP_W-1:0] grp,
    output logic               empty,
    output logic [LCNT_W-1:0]  lcnt
);

    assign empty = ~|grp;

    // Scan upward so the highest set bit wins.
    always_comb begin
        lcnt = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (grp[i]) begin
                lcnt = LCNT_W'(GROUP_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_norm_pipe.sv
// Two-stage CLZ/CLS normaliser with valid/ready on both sides.
// Define CLZ_NORM_SHIFT_EN to include the stage-2 normalising shifter.
module clz_norm_pipe
    import clz_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int GROUP_W = 8,
    localparam int CNT_W  = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_data
);

    localparam int NG     = DATA_W / GROUP_W;
    localparam int LCNT_W = cnt_w(GROUP_W);

    logic              s1_valid_d, s1_valid_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    logic              s1_mode_d, s1_mode_q;
    logic [CNT_W-1:0]  s1_cnt_d, s1_cnt_q;

    logic              s2_valid_d, s2_valid_q;
    logic [CNT_W-1:0]  s2_cnt_d, s2_cnt_q;
    logic              s2_zero_d, s2_zero_q;
    logic [DATA_W-1:0] s2_data_d, s2_data_q;

    logic              s1_adv, s2_adv;
    logic [DATA_W-1:0] tree_in;
    logic [NG-1:0]     g_empty;
    logic [LCNT_W-1:0] g_cnt [NG];
    logic [CNT_W-1:0]  cnt_raw;
    logic              zero_calc;
    logic [DATA_W-1:0] shifted;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // CLS reuses the CLZ tree: sign-relative bits, shifted, with a stop bit.
    always_comb begin
        tree_in = in_data;
        if (in_mode == CLZ_MODE_LS) begin
            tree_in = {in_data[DATA_W-2:0]
                       ^ {(DATA_W-1){in_data[DATA_W-1]}}, 1'b1};
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        clz_group #(
            .GROUP_W(GROUP_W)
        ) u_grp (
            .grp  (tree_in[g*GROUP_W +: GROUP_W]),
            .empty(g_empty[g]),
            .lcnt (g_cnt[g])
        );
    end

    always_comb begin
        cnt_raw = CNT_W'(DATA_W);
        for (int g = 0; g < NG; g++) begin
            if (!g_empty[g]) begin
                cnt_raw = CNT_W'(GROUP_W * (NG - 1 - g))
                        + CNT_W'(g_cnt[g]);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_cnt_d   = s1_cnt_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = in_mode;
                s1_cnt_d  = cnt_raw;
            end
        end
    end

    // In CLS a count of DATA_W-1 means all bits match the MSB.
    always_comb begin
        if (s1_mode_q == CLZ_MODE_LS) begin
            zero_calc = (s1_cnt_q == CNT_W'(DATA_W - 1))
                      && !s1_data_q[DATA_W-1];
        end else begin
            zero_calc = (s1_cnt_q == CNT_W'(DATA_W));
        end
    end

`ifdef CLZ_NORM_SHIFT_EN
    assign shifted = s1_data_q << s1_cnt_q;
`else
    assign shifted = s1_data_q;
`endif

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cnt_d   = s2_cnt_q;
        s2_zero_d  = s2_zero_q;
        s2_data_d  = s2_data_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cnt_d  = s1_cnt_q;
                s2_zero_d = zero_calc;
                s2_data_d = shifted;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= CLZ_MODE_LZ;
            s1_cnt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_cnt   = s2_cnt_q;
    assign out_zero  = s2_zero_q;
    assign out_data  = s2_data_q;

endmodule

// File: tb/tb_clz_norm_pipe.sv
// Randomised and directed bench for clz_norm_pipe against a bit-scan model.
// Expected out_data follows CLZ_NORM_SHIFT_EN.
module tb_clz_norm_pipe;

    localparam int DW   = 32;
    localparam int NOPS = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [5:0]    out_cnt;
    logic          out_zero;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW:0] exp_q [$];
    logic        stall = 1'b0;
    logic [DW+6:0] held = '0;

    clz_norm_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cnt  (out_cnt),
        .out_zero (out_zero),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Plain bit scan from the top, straight from the count definitions.
    function automatic int ref_cnt(input logic [DW-1:0] d, input logic m);
        int n = 0;
        if (!m) begin
            while (n < DW && d[DW-1-n] == 1'b0) n++;
            return n;
        end
        while (n < DW && d[DW-1-n] == d[DW-1]) n++;
        return n - 1;
    endfunction

    function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d,
                                               input int c);
`ifdef CLZ_NORM_SHIFT_EN
        return (c >= DW) ? '0 : (d << c);
`else
        return d + DW'(0 * c);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall <= 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_out", 64'({out_cnt, out_zero, out_data}),
                      64'(held));
            end
            if (in_valid && in_ready) exp_q.push_back({in_mode, in_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    logic [DW:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = ref_cnt(e[DW-1:0], e[DW]);
                    check("cnt", 64'(out_cnt), 64'(c));
                    check("zero", 64'(out_zero), 64'(e[DW-1:0] == '0));
                    check("data", 64'(out_data),
                          64'(ref_data(e[DW-1:0], c)));
                end
            end
            stall <= out_valid && !out_ready;
            held  <= {out_cnt, out_zero, out_data};
        end
    end

    task automatic directed(input logic [DW-1:0] d, input logic m,
                            input int ecnt, input logic ezero,
                            input logic [DW-1:0] edata);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        @(negedge clk);
        check("dir_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("dir_lat2", 64'(out_valid), 64'd1);
        check("dir_cnt", 64'(out_cnt), 64'(ecnt));
        check("dir_zero", 64'(out_zero), 64'(ezero));
        check("dir_data", 64'(out_data), 64'(edata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] rnd_op();
        logic [DW-1:0] v;
        int k;
        k = int'($urandom_range(0, 32));
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = (k >= DW) ? '0 : ($urandom >> k);
            2: v = (k >= DW) ? '1 : ~($urandom >> k);
            default: begin
                case ($urandom_range(0, 3))
                    0: v = '0;
                    1: v = '1;
                    2: v = 32'h0000_0001;
                    default: v = 32'h8000_0000;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ops [4];
        int idx, acc, sent, cyc;
        logic fresh;

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_cnt", 64'(out_cnt), 64'd0);
        check("rst_zero", 64'(out_zero), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_inready", 64'(in_ready), 64'd1);

`ifdef CLZ_NORM_SHIFT_EN
        directed(32'h0001_0000, 1'b0, 15, 1'b0, 32'h8000_0000);
        directed(32'h0000_0000, 1'b0, 32, 1'b1, 32'h0000_0000);
        directed(32'h8000_0000, 1'b0, 0, 1'b0, 32'h8000_0000);
        directed(32'hFFFF_0000, 1'b1, 15, 1'b0, 32'h8000_0000);
        directed(32'hFFFF_FFFF, 1'b1, 31, 1'b0, 32'h8000_0000);
        directed(32'h0000_0001, 1'b1, 30, 1'b0, 32'h4000_0000);
        directed(32'h0000_0000, 1'b1, 31, 1'b1, 32'h0000_0000);
`else
        directed(32'h0001_0000, 1'b0, 15, 1'b0, 32'h0001_0000);
        directed(32'h0000_0000, 1'b0, 32, 1'b1, 32'h0000_0000);
        directed(32'hFFFF_0000, 1'b1, 15, 1'b0, 32'hFFFF_0000);
        directed(32'hFFFF_FFFF, 1'b1, 31, 1'b0, 32'hFFFF_FFFF);
        directed(32'h0000_0001, 1'b1, 30, 1'b0, 32'h0000_0001);
        directed(32'h0000_0000, 1'b1, 31, 1'b1, 32'h0000_0000);
`endif
        idle(3);

        ops[0] = 32'h00F0_0000;
        ops[1] = 32'hFFF0_0000;
        ops[2] = 32'h0000_0003;
        ops[3] = 32'h0000_FFFF;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 3);
            in_valid  = 1'b1;
            in_data   = ops[idx];
            in_mode   = idx[0];
            @(negedge clk);
            if (c == 2) begin
                check("bp_inready", 64'(in_ready), 64'd0);
                check("bp_accepted", 64'(acc), 64'd2);
            end
            if (in_ready) begin
                idx++;
                acc++;
            end
        end
        check("bp_all_sent", 64'(idx), 64'd4);
        idle(6);
        @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0100;
        in_mode   = 1'b0;
        @(posedge clk); #1;
        in_data   = 32'hF000_0000;
        in_mode   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_inready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end
`ifdef CLZ_NORM_SHIFT_EN
        directed(32'h0000_0F00, 1'b0, 20, 1'b0, 32'hF000_0000);
`else
        directed(32'h0000_0F00, 1'b0, 20, 1'b0, 32'h0000_0F00);
`endif
        idle(3);

        sent  = 0;
        cyc   = 0;
        fresh = 1'b1;
        while (sent < NOPS && cyc < 60000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            if (fresh) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = rnd_op();
                in_mode  = $urandom_range(0, 1) == 1;
            end
            @(negedge clk);
            fresh = !in_valid || in_ready;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'(NOPS));
        idle(8);
        @(negedge clk);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
